alu_flt_cvt: RTL and testbench
==============================

# alu_flt_cvt

Multi-cycle integer↔double-precision converter sitting beside the floating-point arithmetic ALU slice in the processor's execute stage. Converts 64-bit signed integers into IEEE-754 binary64 values for the FP arithmetic path, and converts binary64 results back to 64-bit signed integers. A valid/ready handshake is used on both sides. A fixed-latency iterative normalizer (six conditional shift steps) keeps the area small.

## Interface
- `WORDSIZE`, 64: word width. Only 64 is supported (binary64 / int64).
- `clock` input, 1: sole clock; all state changes on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `in_valid` input, 1: request present.
- `in_ready` output, 1: unit can accept a request. High only in IDLE.
- `input_a` input, WORDSIZE: operand. Integer for int→float, binary64 for float→int.
- `operation` input, 6: `6'b01_0100` = int64→double (RNE); `6'b01_0101` = double→int64 (round toward zero).
- `out_valid` output, 1: result present.
- `out_ready` input, 1: consumer takes the result.
- `out` output, WORDSIZE: converted value.
- `flag_nv` output, 1: invalid-operation flag.
- `flag_nx` output, 1: inexact flag.

## Operation
- Accept occurs when `in_valid && in_ready`. Operand and opcode are registered at this point and later input changes are ignored.
- States: IDLE → PREP → NORM (6 cycles, 3-bit step counter) → ROUND → DONE → IDLE.
- int→float:
  - PREP: sign = a[63]; mag = |a|, unsigned (−2^63 → 0x8000_0000_0000_0000); lz = 0.
  - NORM step k (k = 0..5, shift s = 32,16,8,4,2,1): if mag[63:64−s] == 0, then mag <<= s and lz += s.
  - ROUND: exp = 1086 − lz. Mantissa = mag[62:11], guard = mag[10], sticky = |mag[9:0]. RNE: increment when guard && (sticky || lsb). Mantissa carry-out increments exp. nx = guard | sticky.
  - Zero input → +0.0 (0x0000…0), nx = 0.
- float→int:
  - PREP: e = a[62:52], E = e − 1023, sig = {1, a[51:0], 11'b0}; set shift amount = 63 − E.
  - Special cases resolved in PREP; NORM still runs so latency stays fixed.
    - NaN (e = 2047, frac ≠ 0) → 0x7FFF_FFFF_FFFF_FFFF, nv = 1.
    - +inf, or E ≥ 63 with positive sign → 0x7FFF_FFFF_FFFF_FFFF, nv = 1.
    - −inf, or negative with E ≥ 63 and not exactly −2^63 → 0x8000_0000_0000_0000, nv = 1.
    - Exactly −2^63 → 0x8000_0000_0000_0000, nv = 0, nx = 0.
    - E < 0 (includes subnormals and ±0) → 0. nx = 1 unless the input is ±0.
  - NORM step k: if the shift amount has bit (5−k) set, sig >>= 2^(5−k). Shifted-out ones accumulate into sticky.
  - ROUND: result = sign ? −sig : sig; nx = sticky.
- Unknown opcode: accepted, `out` = 0, both flags 0, same latency.
- nv and nx are never both set.

## Timing
- Reset: state = IDLE, `in_ready` = 1, `out_valid` = 0, `out` = 0, `flag_nv` = 0, `flag_nx` = 0, step counter = 0.
- Accept at edge E0. `out_valid` rises after edge E8: fixed latency of 8 cycles, independent of operand.
- In DONE, `out`, `flag_nv` and `flag_nx` are held stable while `out_valid && !out_ready`.
- At the edge where `out_valid && out_ready`, the unit returns to IDLE: `out_valid` = 0, `in_ready` = 1. There is no same-cycle re-accept, so the minimum issue interval is 10 cycles.
- `in_ready` = 0 from the cycle after accept until the return to IDLE.
- Outputs stay registered in non-DONE states: `out` and flags keep their last values. Consumers must qualify them with `out_valid`.
- Reset asserted in any state (including mid-NORM or DONE) → IDLE with reset values at the next edge. The in-flight result is discarded.

## Test plan
- int→float: 1 → 0x3FF0_0000_0000_0000, nx = 0. −2 → 0xC000_0000_0000_0000. 0 → 0x0. −2^63 → 0xC3E0_0000_0000_0000. `out_valid` asserted exactly 8 cycles after accept.
- Rounding: 0x0020_0000_0000_0001 (2^53+1) → 0x4340_0000_0000_0000, nx = 1 (tie to even). 0x0020_0000_0000_0003 → 0x4340_0000_0000_0002, nx = 1.
- float→int: 2.5 (0x4004_0000_0000_0000) → 2, nx = 1. −1.5 (0xBFF8_0000_0000_0000) → 0xFFFF_FFFF_FFFF_FFFF, nx = 1. 0x3FE0_0000_0000_0000 (0.5) → 0, nx = 1.
- Specials: NaN 0x7FF8_0000_0000_0000 → 0x7FFF_FFFF_FFFF_FFFF, nv = 1. 1e19 (0x43E1_58E4_6091_3D00) → 0x7FFF…F, nv = 1. −2^63 (0xC3E0_0000_0000_0000) → 0x8000_0000_0000_0000, flags 0.
- Handshake: hold `out_ready` = 0 for 5 cycles in DONE → `out` and flags stable and `in_ready` = 0 throughout. Raise `out_ready` → `in_ready` = 1 on the next cycle. `in_valid` held high continuously → one accept per transaction.
- Reset asserted on NORM step 3 → next cycle IDLE, `out_valid` = 0, `in_ready` = 1. A subsequent conversion of 1 → 0x3FF0_0000_0000_0000 with normal latency.

Source files
------------

// File: rtl/alu_flt_cvt.sv
// Iterative int64 <-> binary64 converter with valid/ready handshakes on both sides.
// Fixed 8-cycle latency: PREP, six conditional shift steps, ROUND.
module alu_flt_cvt #(
  parameter int WORDSIZE = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [5:0]          operation,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out,
  output logic                flag_nv,
  output logic                flag_nx
);

  localparam logic [5:0]  OP_I2F  = 6'b01_0100;
  localparam logic [5:0]  OP_F2I  = 6'b01_0101;
  localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] DBL_MIN = 64'hC3E0_0000_0000_0000;

  typedef enum logic [2:0] {IDLE, PREP, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic [2:0]  step;
  logic [5:0]  op_r;
  logic [63:0] a_r;
  logic        sign;
  logic [63:0] mag;      // int->float magnitude, or float->int significand
  logic [6:0]  lz;
  logic [5:0]  shamt;
  logic        sticky;
  logic        special;
  logic [63:0] spec_val;
  logic        spec_nv;
  logic        spec_nx;

  logic [10:0] f_exp;
  logic [51:0] f_frac;
  logic        f_nan;
  logic        f_big;
  logic        f_tiny;
  logic        f_min;
  logic [6:0]  norm_amt;
  logic [6:0]  top_shift;
  logic        top_zero;
  logic        shift_take;
  logic [63:0] out_mask;
  logic [10:0] rnd_exp;
  logic        rnd_guard;
  logic        rnd_sticky;
  logic        rnd_inc;
  logic [52:0] rnd_sum;
  logic [63:0] i2f_res;
  logic [63:0] f2i_res;

  always_comb begin
    f_exp  = a_r[62:52];
    f_frac = a_r[51:0];
    f_nan  = (&f_exp) && (|f_frac);
    f_big  = f_exp >= 11'd1086;   // unbiased exponent >= 63
    f_tiny = f_exp < 11'd1023;    // unbiased exponent < 0
    f_min  = a_r == DBL_MIN;
  end

  // Step k shifts by 32 >> k; int->float tests the top bits, float->int tests shamt bit 5-k.
  always_comb begin
    norm_amt   = 7'd32 >> step;
    top_shift  = 7'd64 - norm_amt;
    top_zero   = (mag >> top_shift) == 64'd0;
    shift_take = shamt[3'd5 - step];
    out_mask   = (64'd1 << norm_amt) - 64'd1;
  end

  always_comb begin
    rnd_exp    = 11'd1086 - {4'd0, lz};
    rnd_guard  = mag[10];
    rnd_sticky = |mag[9:0];
    rnd_inc    = rnd_guard & (rnd_sticky | mag[11]);
    rnd_sum    = {1'b0, mag[62:11]} + {52'd0, rnd_inc};
    i2f_res    = {sign, rnd_exp + {10'd0, rnd_sum[52]}, rnd_sum[51:0]};
    f2i_res    = sign ? (~mag + 64'd1) : mag;
  end

  // NOTE: every register here is state, so all updates are non-blocking (<=) to avoid
  // read-before-write races between the datapath and the FSM within one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      flag_nv   <= 1'b0;
      flag_nx   <= 1'b0;
      op_r      <= '0;
      a_r       <= '0;
      sign      <= 1'b0;
      mag       <= '0;
      lz        <= '0;
      shamt     <= '0;
      sticky    <= 1'b0;
      special   <= 1'b0;
      spec_val  <= '0;
      spec_nv   <= 1'b0;
      spec_nx   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= input_a;
            op_r     <= operation;
            in_ready <= 1'b0;
            state    <= PREP;
          end
        end

        PREP: begin
          sign   <= a_r[63];
          lz     <= '0;
          sticky <= 1'b0;
          step   <= '0;
          state  <= NORM;
          if (op_r == OP_I2F) begin
            mag     <= a_r[63] ? (~a_r + 64'd1) : a_r;
            special <= 1'b0;
          end else begin
            mag      <= {1'b1, f_frac, 11'd0};
            shamt    <= 6'd62 - f_exp[5:0];   // low bits of 1086 - e, i.e. 63 - E
            special  <= f_nan | f_big | f_tiny;
            spec_nv  <= f_nan | (f_big & ~f_min);
            spec_nx  <= ~f_big & f_tiny & (|a_r[62:0]);
            spec_val <= (f_big & ~f_nan & a_r[63]) ? INT_MIN :
                        (f_big ? INT_MAX : 64'd0);
          end
        end

        NORM: begin
          if (op_r == OP_I2F) begin
            if (top_zero) begin
              mag <= mag << norm_amt;
              lz  <= lz + norm_amt;
            end
          end else if (shift_take) begin
            mag    <= mag >> norm_amt;
            sticky <= sticky | (|(mag & out_mask));
          end
          if (step == 3'd5) begin
            step  <= '0;
            state <= ROUND;
          end else begin
            step <= step + 3'd1;
          end
        end

        ROUND: begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (op_r == OP_I2F) begin
            out     <= (mag == 64'd0) ? 64'd0 : i2f_res;
            flag_nv <= 1'b0;
            flag_nx <= rnd_guard | rnd_sticky;
          end else if (op_r == OP_F2I) begin
            out     <= special ? spec_val : f2i_res;
            flag_nv <= special & spec_nv;
            flag_nx <= special ? spec_nx : sticky;
          end else begin
            out     <= '0;
            flag_nv <= 1'b0;
            flag_nx <= 1'b0;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flt_cvt.sv
// Self-checking bench for alu_flt_cvt: vector table through a scoreboard queue,
// plus hand-written handshake, back-to-back issue and mid-flight reset sequences.
module tb_alu_flt_cvt;

  localparam logic [5:0] OP_I2F = 6'b01_0100;
  localparam logic [5:0] OP_F2I = 6'b01_0101;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [63:0] a;
    logic [63:0] res;
    logic        nv;
    logic        nx;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        nv;
    logic        nx;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] input_a;
  logic [5:0]  operation;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        flag_nv;
  logic        flag_nx;

  int   checks  = 0;
  int   errors  = 0;
  int   accepts = 0;
  vec_t vecs[$];
  exp_t sb[$];

  alu_flt_cvt #(.WORDSIZE(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input_a   (input_a),
    .operation (operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag_nv   (flag_nv),
    .flag_nx   (flag_nx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on every output handshake, sampled mid-cycle before the edge.
  always @(negedge clock) begin
    if (!reset && in_valid && in_ready) accepts++;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h with no expected entry", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".out"}, out, e.res);
        check({e.name, ".nv"}, 64'(flag_nv), 64'(e.nv));
        check({e.name, ".nx"}, 64'(flag_nx), 64'(e.nx));
      end
    end
  end

  // Called #1 after an edge; returns #1 after the accept edge with garbage on the inputs.
  task automatic issue(input logic [5:0] op, input logic [63:0] a);
    int n;
    n = 0;
    in_valid  = 1'b1;
    operation = op;
    input_a   = a;
    while (!in_ready && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clock); #1;
      in_valid  = 1'b0;
      input_a   = 64'hDEAD_BEEF_0BAD_F00D;
      operation = 6'h3F;
    end
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clock); #1;
      lat++;
    end
    check({name, ".latency"}, 64'(lat), 64'd8);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.name = v.name;
    e.res  = v.res;
    e.nv   = v.nv;
    e.nx   = v.nx;
    sb.push_back(e);
    issue(v.op, v.a);
    wait_valid(v.name);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    vec_t one;
    exp_t e;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    input_a   = '0;
    operation = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.out", out, 64'd0);
    check("reset.nv", 64'(flag_nv), 64'd0);
    check("reset.nx", 64'(flag_nx), 64'd0);
    reset = 1'b0;

    vecs.push_back('{"i2f_one",      OP_I2F, 64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0});
    vecs.push_back('{"i2f_m2",       OP_I2F, 64'hFFFF_FFFF_FFFF_FFFE, 64'hC000_0000_0000_0000, 1'b0, 1'b0});
    vecs.push_back('{"i2f_zero",     OP_I2F, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0});
    vecs.push_back('{"i2f_min",      OP_I2F, 64'h8000_0000_0000_0000, 64'hC3E0_0000_0000_0000, 1'b0, 1'b0});
    vecs.push_back('{"i2f_tie_even", OP_I2F, 64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000, 1'b0, 1'b1});
    vecs.push_back('{"i2f_tie_up",   OP_I2F, 64'h0020_0000_0000_0003, 64'h4340_0000_0000_0002, 1'b0, 1'b1});
    vecs.push_back('{"i2f_max_carry",OP_I2F, 64'h7FFF_FFFF_FFFF_FFFF, 64'h43E0_0000_0000_0000, 1'b0, 1'b1});
    vecs.push_back('{"i2f_three",    OP_I2F, 64'h0000_0000_0000_0003, 64'h4008_0000_0000_0000, 1'b0, 1'b0});
    vecs.push_back('{"f2i_2p5",      OP_F2I, 64'h4004_0000_0000_0000, 64'h0000_0000_0000_0002, 1'b0, 1'b1});
    vecs.push_back('{"f2i_m1p5",     OP_F2I, 64'hBFF8_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1});
    vecs.push_back('{"f2i_half",     OP_F2I, 64'h3FE0_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b1});
    vecs.push_back('{"f2i_one",      OP_F2I, 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0});
    vecs.push_back('{"f2i_negzero",  OP_F2I, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0});
    vecs.push_back('{"f2i_subnorm",  OP_F2I, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b0, 1'b1});
    vecs.push_back('{"f2i_2p53m1",   OP_F2I, 64'h433F_FFFF_FFFF_FFFF, 64'h001F_FFFF_FFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{"f2i_e62",      OP_F2I, 64'h43DF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FC00, 1'b0, 1'b0});
    vecs.push_back('{"f2i_nan",      OP_F2I, 64'h7FF8_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{"f2i_1e19",     OP_F2I, 64'h43E1_58E4_6091_3D00, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{"f2i_pinf",     OP_F2I, 64'h7FF0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{"f2i_ninf",     OP_F2I, 64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0});
    vecs.push_back('{"f2i_min",      OP_F2I, 64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0});
    vecs.push_back('{"f2i_below_min",OP_F2I, 64'hC3E0_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b1, 1'b0});
    vecs.push_back('{"bad_opcode",   6'h3F,  64'h0000_0000_0000_1234, 64'h0000_0000_0000_0000, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Back-pressure in DONE: result and flags hold, no new accept.
    out_ready = 1'b0;
    e = '{"hold_2p5", 64'h0000_0000_0000_0002, 1'b0, 1'b1};
    sb.push_back(e);
    issue(OP_F2I, 64'h4004_0000_0000_0000);
    in_valid = 1'b1;
    wait_valid("hold_2p5");
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      check("hold.out", out, 64'h0000_0000_0000_0002);
      check("hold.nx", 64'(flag_nx), 64'd1);
      check("hold.nv", 64'(flag_nv), 64'd0);
      check("hold.out_valid", 64'(out_valid), 64'd1);
      check("hold.in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("release.in_ready", 64'(in_ready), 64'd1);
    check("release.out_valid", 64'(out_valid), 64'd0);

    // in_valid held high for 25 edges: accepts land 10 cycles apart, so exactly 3.
    e = '{"stream_one", 64'h3FF0_0000_0000_0000, 1'b0, 1'b0};
    repeat (3) sb.push_back(e);
    seen = accepts;
    in_valid  = 1'b1;
    operation = OP_I2F;
    input_a   = 64'd1;
    repeat (25) @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(posedge clock); #1;
    end
    check("stream.accepts", 64'(accepts - seen), 64'd3);
    check("stream.drained", 64'(sb.size()), 64'd0);
    @(posedge clock); #1;

    // Reset during NORM step 3 discards the in-flight result.
    issue(OP_I2F, 64'h0000_0000_0000_0005);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset.out_valid", 64'(out_valid), 64'd0);
    check("midreset.in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1;
    end
    check("midreset.no_stale", 64'(seen), 64'd0);
    one = '{"post_reset_one", OP_I2F, 64'h1, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0};
    run_vec(one);

    check("scoreboard.empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
